// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch, load/store and memory-port signals of the port arbiter.
// Latency: none, wiring only.
// Backpressure: level requests held until the matching completion pulse.
interface mem_port_arbiter_if;
    // instruction fetch side
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_flush;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        if_err;
    // load/store side
    logic        dm_req;
    logic        dm_we;
    logic [3:0]  dm_be;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        memOp_done;
    logic        dm_err;
    logic        arb_eqmem;
    logic        stall_mem;
    // shared memory port
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    // arbiter view: owns the memory port, serves both requesters
    modport master (
        input  if_req, if_addr, if_flush,
        input  dm_req, dm_we, dm_be, dm_addr, dm_wdata,
        input  mem_ack, mem_rdata,
        output if_ack, if_rdata, if_err,
        output dm_rdata, memOp_done, dm_err, arb_eqmem, stall_mem,
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata
    );

    // environment view: requesters plus the memory/cache
    modport slave (
        output if_req, if_addr, if_flush,
        output dm_req, dm_we, dm_be, dm_addr, dm_wdata,
        output mem_ack, mem_rdata,
        input  if_ack, if_rdata, if_err,
        input  dm_rdata, memOp_done, dm_err, arb_eqmem, stall_mem,
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and load/store; data wins, starvation counter lets fetch through.
// Latency: grant registered, mem_req the next cycle, completion pulse the cycle after mem_ack (3 cycles min).
// Backpressure: one transaction in flight; requesters hold req until pulse; watchdog aborts after TIMEOUT cycles.
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255,
    parameter int TO_W         = 8
) (
    input logic                clk,
    input logic                nrst,
    mem_port_arbiter_if.master bus
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;

    localparam int              SC_W    = $clog2(STARVE_LIMIT + 1);
    localparam logic [SC_W-1:0] SC_MAX  = SC_W'(STARVE_LIMIT);
    // to_cnt holds the number of ack-less cycles already spent, so the
    // TIMEOUT-th such cycle is the one seeing TIMEOUT-1 in the counter
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    logic [1:0]      state;
    logic [1:0]      state_nxt;
    logic [SC_W-1:0] starve_cnt;
    logic [TO_W-1:0] to_cnt;
    logic            flush_pending;

    logic            busy;
    logic            in_fetch;
    logic            in_data;
    logic            grant_fetch;
    logic            grant_data;
    logic            done_ack;
    logic            done_timeout;
    logic            finish;
    logic            fetch_drop;

    // payload of the granted requester, frozen for the whole transaction
    logic            lat_we;
    logic [3:0]      lat_be;
    logic [31:0]     lat_addr;
    logic [31:0]     lat_wdata;

    logic            if_ack_q;
    logic            if_err_q;
    logic [31:0]     if_rdata_q;
    logic            done_q;
    logic            dm_err_q;
    logic [31:0]     dm_rdata_q;

    assign busy     = (state != ST_IDLE);
    assign in_fetch = (state == ST_FETCH);
    assign in_data  = (state == ST_DATA);

    // fetch is granted when data is absent or data has starved it long enough;
    // a redirect in the same cycle makes the fetch address stale, so no grant
    assign grant_fetch = (state == ST_IDLE) & bus.if_req & ~bus.if_flush
                       & (~bus.dm_req | (starve_cnt == SC_MAX));
    assign grant_data  = (state == ST_IDLE) & bus.dm_req & ~grant_fetch;

    // an ack on the watchdog cycle counts as a normal completion
    assign done_ack     = busy & bus.mem_ack;
    assign done_timeout = busy & ~bus.mem_ack & (to_cnt == TO_LAST);
    assign finish       = done_ack | done_timeout;

    // a fetch response is thrown away if any redirect hit it, including on the ack cycle
    assign fetch_drop = flush_pending | bus.if_flush;

    // next-state selection: grant from IDLE, return to IDLE on ack or watchdog
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (grant_fetch) begin
                    state_nxt = ST_FETCH;
                end else if (grant_data) begin
                    state_nxt = ST_DATA;
                end
            end
            ST_FETCH, ST_DATA: begin
                if (finish) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // arbiter state register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // capture the winner's payload at grant; fetch is always a full-word read
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            lat_we    <= 1'b0;
            lat_be    <= 4'h0;
            lat_addr  <= 32'h0;
            lat_wdata <= 32'h0;
        end else if (grant_fetch) begin
            lat_we    <= 1'b0;
            lat_be    <= 4'hF;
            lat_addr  <= bus.if_addr;
            lat_wdata <= 32'h0;
        end else if (grant_data) begin
            lat_we    <= bus.dm_we;
            lat_be    <= bus.dm_be;
            lat_addr  <= bus.dm_addr;
            lat_wdata <= bus.dm_wdata;
        end
    end

    // count data grants that overtook a waiting fetch; a fetch grant repays the debt
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            starve_cnt <= '0;
        end else if (grant_fetch) begin
            starve_cnt <= '0;
        end else if (grant_data && bus.if_req && (starve_cnt != SC_MAX)) begin
            starve_cnt <= starve_cnt + SC_W'(1);
        end
    end

    // watchdog: cycles spent on the port without an ack
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            to_cnt <= '0;
        end else if (!busy || finish) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + TO_W'(1);
        end
    end

    // remember a redirect seen while a fetch is on the port
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            flush_pending <= 1'b0;
        end else if (!in_fetch || finish) begin
            flush_pending <= 1'b0;
        end else if (bus.if_flush) begin
            flush_pending <= 1'b1;
        end
    end

    // completion pulses and returned data, routed to the transaction owner
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            if_ack_q   <= 1'b0;
            if_err_q   <= 1'b0;
            if_rdata_q <= 32'h0;
            done_q     <= 1'b0;
            dm_err_q   <= 1'b0;
            dm_rdata_q <= 32'h0;
        end else begin
            if_ack_q <= 1'b0;
            if_err_q <= 1'b0;
            done_q   <= 1'b0;
            dm_err_q <= 1'b0;
            if (in_fetch && done_ack && !fetch_drop) begin
                if_ack_q   <= 1'b1;
                if_rdata_q <= bus.mem_rdata;
            end
            if (in_fetch && done_timeout && !fetch_drop) begin
                if_err_q <= 1'b1;
            end
            if (in_data && finish) begin
                done_q     <= 1'b1;
                dm_err_q   <= done_timeout;
                dm_rdata_q <= (done_ack && !lat_we) ? bus.mem_rdata : 32'h0;
            end
        end
    end

    assign bus.mem_req   = busy;
    assign bus.mem_we    = lat_we;
    assign bus.mem_be    = lat_be;
    assign bus.mem_addr  = lat_addr;
    assign bus.mem_wdata = lat_wdata;

    assign bus.if_ack     = if_ack_q;
    assign bus.if_err     = if_err_q;
    assign bus.if_rdata   = if_rdata_q;
    assign bus.memOp_done = done_q;
    assign bus.dm_err     = dm_err_q;
    assign bus.dm_rdata   = dm_rdata_q;

    // issue-stage interlock; the reset term keeps the stall low while the core is held in reset
    assign bus.arb_eqmem = in_data;
    assign bus.stall_mem = nrst & bus.dm_req & ~in_data & ~done_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed checks of mem_port_arbiter against a transaction-level reference model.
// Latency: one bench cycle per clock; outputs sampled on the falling edge.
// Backpressure: bench requesters hold req until their pulse, bench memory acks after a chosen delay.
module tb_mem_port_arbiter;
    localparam int LIMIT = 4;
    localparam int TMO   = 255;

    logic clk  = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if bus();

    mem_port_arbiter #(.STARVE_LIMIT(LIMIT), .TIMEOUT(TMO), .TO_W(8)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;
    int cycle = 0;

    // reference model: who owns the port, for how long, and the pending pulses
    int          m_own;     // 0 none, 1 fetch, 2 data
    int          m_age;
    int          m_starve;
    bit          m_fp, m_ifack, m_iferr, m_done, m_derr, m_we;
    logic [31:0] m_ifrd, m_drd, m_addr, m_wd;
    logic [3:0]  m_be;

    // stimulus knobs and bench memory
    int dm_pct, if_pct, flush_pct, idle_ack_pct, we_mode, ack_tgt, flush_cyc;
    int mm_cnt, mm_tgt;

    // observations taken from the DUT for phase-level checks
    int n_req, n_done, n_derr, n_ifack, n_iferr, n_stall, n_eq, done_cyc;
    bit prev_req;
    int dlog[$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40)
                $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cycle, act, exp);
        end
    endtask

    function automatic bit pct(input int p);
        return int'($urandom_range(99, 0)) < p;
    endfunction

    task automatic model_reset();
        m_own = 0; m_age = 0; m_starve = 0; m_fp = 0;
        m_ifack = 0; m_iferr = 0; m_done = 0; m_derr = 0; m_we = 0;
        m_ifrd = 0; m_drd = 0; m_addr = 0; m_wd = 0; m_be = 0;
        mm_cnt = 0; prev_req = 0;
    endtask

    task automatic clr_obs();
        n_req = 0; n_done = 0; n_derr = 0; n_ifack = 0; n_iferr = 0;
        n_stall = 0; n_eq = 0; done_cyc = -1; dlog.delete();
    endtask

    // one clock of the specification's rules, applied with the inputs present at the edge
    task automatic model_step();
        bit fetch_wins;
        m_ifack = 0; m_iferr = 0; m_done = 0; m_derr = 0;
        if (m_own == 0) begin
            fetch_wins = bus.if_req && !bus.if_flush && (!bus.dm_req || m_starve == LIMIT);
            m_age = 0;
            if (fetch_wins) begin
                m_own = 1; m_starve = 0;
                m_addr = bus.if_addr; m_we = 0; m_be = 4'hF; m_wd = 0;
            end else if (bus.dm_req) begin
                m_own = 2;
                if (bus.if_req && m_starve < LIMIT) m_starve++;
                m_addr = bus.dm_addr; m_we = bus.dm_we; m_be = bus.dm_be; m_wd = bus.dm_wdata;
            end
        end else begin
            m_age++;
            if (bus.mem_ack || m_age == TMO) begin
                if (m_own == 1) begin
                    if (!(m_fp || bus.if_flush)) begin
                        m_ifack = bus.mem_ack;
                        m_iferr = !bus.mem_ack;
                        m_ifrd  = bus.mem_rdata;
                    end
                end else begin
                    m_done = 1;
                    m_derr = !bus.mem_ack;
                    m_drd  = (bus.mem_ack && !m_we) ? bus.mem_rdata : 32'h0;
                end
                m_own = 0; m_fp = 0;
            end else if (m_own == 1 && bus.if_flush) begin
                m_fp = 1;
            end
        end
    endtask

    task automatic new_dm();
        bus.dm_req   = 1'b1;
        bus.dm_addr  = $urandom;
        bus.dm_wdata = $urandom;
        bus.dm_be    = 4'($urandom);
        bus.dm_we    = (we_mode == 2) ? 1'($urandom) : (we_mode == 1);
    endtask

    task automatic new_if();
        bus.if_req  = 1'b1;
        bus.if_addr = $urandom;
    endtask

    // requesters and memory react to the pulses of the current cycle
    task automatic drive();
        if (m_own != 0) begin
            if (mm_cnt == 0) mm_tgt = (ack_tgt == 0) ? int'($urandom_range(4, 1)) : ack_tgt;
            mm_cnt++;
            bus.mem_ack = (mm_cnt == mm_tgt);
        end else begin
            mm_cnt = 0;
            bus.mem_ack = pct(idle_ack_pct);
        end
        bus.mem_rdata = $urandom;
        if (bus.dm_req) begin
            if (m_done) begin
                if (pct(dm_pct)) new_dm(); else bus.dm_req = 1'b0;
            end
        end else if (pct(dm_pct)) new_dm();
        if (bus.if_req) begin
            if (m_ifack || m_iferr) begin
                if (pct(if_pct)) new_if(); else bus.if_req = 1'b0;
            end
        end else if (pct(if_pct)) new_if();
        bus.if_flush = (cycle == flush_cyc) || pct(flush_pct);
    endtask

    task automatic compare();
        check("mem_req",    bus.mem_req,    m_own != 0);
        check("arb_eqmem",  bus.arb_eqmem,  m_own == 2);
        check("stall_mem",  bus.stall_mem,  bus.dm_req && m_own != 2 && !m_done);
        check("if_ack",     bus.if_ack,     m_ifack);
        check("if_err",     bus.if_err,     m_iferr);
        check("memOp_done", bus.memOp_done, m_done);
        check("dm_err",     bus.dm_err,     m_derr);
        if (m_own != 0) begin
            check("mem_we",    bus.mem_we,    m_we);
            check("mem_be",    bus.mem_be,    m_be);
            check("mem_addr",  bus.mem_addr,  m_addr);
            check("mem_wdata", bus.mem_wdata, m_wd);
        end
        if (m_ifack)           check("if_rdata", bus.if_rdata, m_ifrd);
        if (m_done && !m_derr) check("dm_rdata", bus.dm_rdata, m_drd);
        if (bus.mem_req) n_req++;
        if (bus.mem_req && !prev_req) dlog.push_back(bus.arb_eqmem ? 2 : 1);
        prev_req = bus.mem_req;
        if (bus.memOp_done) begin n_done++; done_cyc = cycle; end
        if (bus.dm_err)    n_derr++;
        if (bus.if_ack)    n_ifack++;
        if (bus.if_err)    n_iferr++;
        if (bus.stall_mem) n_stall++;
        if (bus.arb_eqmem) n_eq++;
    endtask

    // entered and left at posedge+1
    task automatic cyc();
        drive();
        #4;
        compare();
        @(posedge clk);
        model_step();
        cycle++;
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_mem_req"},   bus.mem_req,    0);
        check({tag, "_mem_we"},    bus.mem_we,     0);
        check({tag, "_mem_be"},    bus.mem_be,     0);
        check({tag, "_mem_addr"},  bus.mem_addr,   0);
        check({tag, "_mem_wdata"}, bus.mem_wdata,  0);
        check({tag, "_if_ack"},    bus.if_ack,     0);
        check({tag, "_if_err"},    bus.if_err,     0);
        check({tag, "_if_rdata"},  bus.if_rdata,   0);
        check({tag, "_done"},      bus.memOp_done, 0);
        check({tag, "_dm_err"},    bus.dm_err,     0);
        check({tag, "_dm_rdata"},  bus.dm_rdata,   0);
        check({tag, "_eqmem"},     bus.arb_eqmem,  0);
        check({tag, "_stall"},     bus.stall_mem,  0);
    endtask

    task automatic do_reset();
        bus.dm_req = 0; bus.if_req = 0; bus.if_flush = 0; bus.mem_ack = 0;
        nrst = 1'b0;
        #1;
        check_zero("rst");
        @(posedge clk);
        #1;
        nrst = 1'b1;
        model_reset();
    endtask

    initial begin
        bus.if_req = 0; bus.if_addr = 0; bus.if_flush = 0;
        bus.dm_req = 0; bus.dm_we = 0; bus.dm_be = 0; bus.dm_addr = 0; bus.dm_wdata = 0;
        bus.mem_ack = 0; bus.mem_rdata = 0;
        dm_pct = 0; if_pct = 0; flush_pct = 0; idle_ack_pct = 0;
        we_mode = 0; ack_tgt = 1; flush_cyc = -1; mm_tgt = 0;
        model_reset();
        clr_obs();
        @(posedge clk);
        #1;
        check_zero("por");
        nrst = 1'b1;

        // single load, ack two cycles after mem_req rises
        clr_obs();
        begin
            int t0;
            t0 = cycle; ack_tgt = 3; we_mode = 0; dm_pct = 100;
            cyc();
            dm_pct = 0;
            repeat (7) cyc();
            check("ld_done_lat", done_cyc - t0, 4);
            check("ld_req_cycles", n_req, 3);
            check("ld_eqmem_cycles", n_eq, 3);
            check("ld_stall_cycles", n_stall, 1);
            check("ld_done_count", n_done, 1);
        end

        // data and fetch both held, zero-wait stores: fetch gets every fifth grant
        do_reset();
        clr_obs();
        ack_tgt = 1; we_mode = 1; dm_pct = 100; if_pct = 100;
        repeat (26) cyc();
        dm_pct = 0; if_pct = 0;
        repeat (8) cyc();
        check("starve_grants", dlog.size() >= 10, 1);
        for (int i = 0; i < 10 && i < dlog.size(); i++)
            check($sformatf("starve_grant%0d", i), dlog[i], (i == 4 || i == 9) ? 1 : 2);

        // redirect one cycle before the fetch ack: response dropped, fetch re-granted
        do_reset();
        clr_obs();
        begin
            int t0;
            t0 = cycle; ack_tgt = 3; flush_cyc = t0 + 2; if_pct = 100;
            cyc();
            if_pct = 0;
            repeat (11) cyc();
            flush_cyc = -1;
            check("fl_ifack_count", n_ifack, 1);
            check("fl_iferr_count", n_iferr, 0);
            check("fl_req_cycles", n_req, 6);
            check("fl_grants", dlog.size(), 2);
        end

        // hung load: watchdog aborts after TIMEOUT cycles, then a normal load
        do_reset();
        clr_obs();
        begin
            int t0;
            t0 = cycle; ack_tgt = -1; we_mode = 0; dm_pct = 100;
            cyc();
            dm_pct = 0;
            repeat (262) cyc();
            check("to_req_cycles", n_req, TMO);
            check("to_done_lat", done_cyc - t0, TMO + 1);
            check("to_done_count", n_done, 1);
            check("to_err_count", n_derr, 1);
            ack_tgt = 2; dm_pct = 100;
            cyc();
            dm_pct = 0;
            repeat (8) cyc();
            check("to_after_done", n_done, 2);
            check("to_after_err", n_derr, 1);
        end

        // ack lands on the watchdog cycle: ordinary completion
        clr_obs();
        begin
            int t0;
            t0 = cycle; ack_tgt = TMO; dm_pct = 100;
            cyc();
            dm_pct = 0;
            repeat (262) cyc();
            check("edge_req_cycles", n_req, TMO);
            check("edge_done_lat", done_cyc - t0, TMO + 1);
            check("edge_err_count", n_derr, 0);
        end

        // reset in the middle of a data transaction with dm_req still held
        clr_obs();
        ack_tgt = -1; dm_pct = 100;
        cyc();
        dm_pct = 0;
        repeat (4) cyc();
        check("mid_req_before", bus.mem_req, 1);
        #2;
        nrst = 1'b0;
        #1;
        check_zero("mid");
        @(posedge clk);
        #1;
        nrst = 1'b1;
        model_reset();
        ack_tgt = 2;
        check("mid_first_idle", bus.mem_req, 0);
        cyc();
        check("mid_regrant_req", bus.mem_req, 1);
        check("mid_regrant_eq", bus.arb_eqmem, 1);
        repeat (8) cyc();

        // random traffic with redirects and stray idle acks
        clr_obs();
        ack_tgt = 0; we_mode = 2; dm_pct = 40; if_pct = 50; flush_pct = 5; idle_ack_pct = 10;
        repeat (3000) cyc();
        dm_pct = 0; if_pct = 0; flush_pct = 0; idle_ack_pct = 0;
        repeat (20) cyc();
        check("rnd_idle_end", bus.mem_req, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
